// File: rtl/register_file_32x32_if.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_32x32_if
//  Description : Write-back and operand-fetch bundle for the 32x32 register
//                file. The master (datapath) drives the write port and read
//                addresses; the slave (register file) returns read data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface register_file_32x32_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int OUT_WIDTH  = 8
);
    logic                  we3;
    logic [ADDR_WIDTH-1:0] wa3;
    logic [DATA_WIDTH-1:0] wd3;
    logic [ADDR_WIDTH-1:0] ra1;
    logic [ADDR_WIDTH-1:0] ra2;
    logic [OUT_WIDTH-1:0]  saida_rd1;
    logic [OUT_WIDTH-1:0]  saida_rd2;

    modport master (
        output we3, wa3, wd3, ra1, ra2,
        input  saida_rd1, saida_rd2
    );

    modport slave (
        input  we3, wa3, wd3, ra1, ra2,
        output saida_rd1, saida_rd2
    );
endinterface
`default_nettype wire

// File: rtl/register_file_32x32.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_32x32
//  Description : 32 x 32-bit register file, two combinational read ports and
//                one clocked write port. x0 is hardwired to zero. Read ports
//                expose only the low OUT_WIDTH bits of each register.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int OUT_WIDTH  = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    register_file_32x32_if.slave  bus
);
    localparam int C_NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [C_NUM_REGS];
    logic                  w_write_ok;
    logic [DATA_WIDTH-1:0] w_rd1_full;
    logic [DATA_WIDTH-1:0] w_rd2_full;

    // Writes to x0 are discarded so it can never hold anything but zero.
    assign w_write_ok = bus.we3 && (bus.wa3 != '0);

    // Reset clears every register and wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_ok) begin
            r_regs[bus.wa3] <= bus.wd3;
        end
    end

    // Combinational operand fetch; x0 is forced to zero even before reset.
    always_comb begin
        w_rd1_full = '0;
        w_rd2_full = '0;
        if (bus.ra1 != '0) w_rd1_full = r_regs[bus.ra1];
        if (bus.ra2 != '0) w_rd2_full = r_regs[bus.ra2];
    end

    assign bus.saida_rd1 = w_rd1_full[OUT_WIDTH-1:0];
    assign bus.saida_rd2 = w_rd2_full[OUT_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_register_file_32x32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_32x32
//  Description : Directed self-checking bench for register_file_32x32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_32x32;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    register_file_32x32_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .OUT_WIDTH(8)) bus ();

    register_file_32x32 #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .OUT_WIDTH (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, leaving time for outputs to settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.we3 = 1'b1;
        bus.wa3 = a;
        bus.wd3 = d;
        tick();
        bus.we3 = 1'b0;
    endtask

    task automatic check_rd(input string name, input logic [4:0] a1, input logic [4:0] a2,
                            input logic [7:0] e1, input logic [7:0] e2);
        bus.ra1 = a1;
        bus.ra2 = a2;
        #1;
        n_checks++;
        if (bus.saida_rd1 !== e1) begin
            n_fail++;
            $display("FAIL %s rd1 (ra1=%0d): got %02h expected %02h", name, a1, bus.saida_rd1, e1);
        end
        n_checks++;
        if (bus.saida_rd2 !== e2) begin
            n_fail++;
            $display("FAIL %s rd2 (ra2=%0d): got %02h expected %02h", name, a2, bus.saida_rd2, e2);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd5;
        bus.wd3 = 32'hFFFF_FFFF;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            check_rd("reset_all", 5'(i), 5'(31 - i), 8'h00, 8'h00);
        end
        bus.we3 = 1'b0;
        rst     = 1'b0;
        tick();
        check_rd("reset_x5_unwritten", 5'd5, 5'd5, 8'h00, 8'h00);
    endtask

    task automatic test_basic_write();
        write_reg(5'd1, 32'h0000_00CA);
        write_reg(5'd7, 32'h0000_00FE);
        check_rd("basic", 5'd1, 5'd7, 8'hCA, 8'hFE);
        check_rd("basic_neighbour", 5'd6, 5'd8, 8'h00, 8'h00);
    endtask

    task automatic test_x0_protect();
        bus.we3 = 1'b1;
        bus.wa3 = 5'd0;
        bus.wd3 = 32'h0000_00DB;
        tick();
        tick();
        tick();
        bus.we3 = 1'b0;
        check_rd("x0_protect", 5'd0, 5'd0, 8'h00, 8'h00);
        check_rd("x0_no_alias", 5'd1, 5'd7, 8'hCA, 8'hFE);
    endtask

    task automatic test_write_disable();
        bus.we3 = 1'b0;
        bus.wa3 = 5'd1;
        bus.wd3 = 32'h0000_0055;
        tick();
        tick();
        tick();
        check_rd("write_disable", 5'd1, 5'd1, 8'hCA, 8'hCA);
    endtask

    task automatic test_truncation();
        write_reg(5'd31, 32'h1234_5678);
        write_reg(5'd2,  32'hABCD_EF01);
        check_rd("trunc_dual", 5'd31, 5'd2, 8'h78, 8'h01);
        check_rd("same_addr", 5'd31, 5'd31, 8'h78, 8'h78);
        write_reg(5'd16, 32'h0000_A5C3);
        check_rd("trunc_mid", 5'd16, 5'd2, 8'hC3, 8'h01);
    endtask

    task automatic test_read_during_write();
        write_reg(5'd3, 32'h0000_0011);
        bus.ra1 = 5'd3;
        bus.ra2 = 5'd3;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd3;
        bus.wd3 = 32'h0000_0022;
        #1;
        n_checks++;
        if (bus.saida_rd1 !== 8'h11) begin
            n_fail++;
            $display("FAIL rdw_before: got %02h expected 11", bus.saida_rd1);
        end
        tick();
        bus.we3 = 1'b0;
        n_checks++;
        if (bus.saida_rd1 !== 8'h22) begin
            n_fail++;
            $display("FAIL rdw_after: got %02h expected 22", bus.saida_rd1);
        end
    endtask

    task automatic test_midop_reset();
        rst     = 1'b1;
        bus.we3 = 1'b1;
        bus.wa3 = 5'd9;
        bus.wd3 = 32'h0000_00AA;
        tick();
        rst     = 1'b0;
        bus.we3 = 1'b0;
        check_rd("midreset_pending", 5'd9, 5'd31, 8'h00, 8'h00);
        check_rd("midreset_cleared", 5'd1, 5'd3, 8'h00, 8'h00);
        write_reg(5'd4, 32'h0000_0044);
        check_rd("post_reset_write", 5'd4, 5'd9, 8'h44, 8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.we3  = 1'b0;
        bus.wa3  = '0;
        bus.wd3  = '0;
        bus.ra1  = '0;
        bus.ra2  = '0;
        test_reset();
        test_basic_write();
        test_x0_protect();
        test_write_disable();
        test_truncation();
        test_read_during_write();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
